mult_seq_ctrl: RTL and testbench

Sequencing FSM for the shift-add unsigned multiplier datapath built around the 4-bit M register, the accumulator A and the multiplier register Q.
- Accepts a start request.
- Drives the load enables of M and Q, the clear and add enables of A, and the A:Q right-shift.
- Returns done after WIDTH add/shift iterations.
- Contains no datapath storage. It only reads Q's LSB.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_iter_counter.sv | 32 +++
 rtl/mult_seq_ctrl.sv | 117 +++++++++++
 tb/tb_mult_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the shift-add multiplier sequencer
//   state_t   : FSM state encoding (3 bits)
//   WIDTH_DEF : default operand width / iteration count
//   cnt_width : iteration counter width for a given operand width
package mult_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Counter must hold 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// rtl/mult_iter_counter.sv - add/shift iteration counter for the multiplier sequencer
//   clock, reset : clock and synchronous active-high reset
//   clr          : synchronous clear to 0 (has priority over inc)
//   inc          : synchronous increment
//   count        : iterations completed so far
//   last         : count == WIDTH-1
module mult_iter_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;
    assign last  = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - Moore sequencing FSM for a shift-add unsigned multiplier
//   clock, reset : clock and synchronous active-high reset
//   start        : level request, sampled only in IDLE
//   q0           : LSB of the Q register, sampled in TEST
//   m_load       : load M register (LOAD only)
//   q_load       : parallel-load Q register (LOAD only)
//   a_clear      : clear accumulator A and its carry (LOAD only)
//   a_add        : A <= A + M (ADD only)
//   shift        : shift carry:A:Q right by one (SHIFT only)
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse, product valid in A:Q
//   bit_count    : iterations completed so far
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             q0,
    output logic             m_load,
    output logic             q_load,
    output logic             a_clear,
    output logic             a_add,
    output logic             shift,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_count
);

    state_t r_state;
    state_t w_next;
    logic   w_clr;
    logic   w_inc;
    logic   w_last;

    mult_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clock (clock),
        .reset (reset),
        .clr   (w_clr),
        .inc   (w_inc),
        .count (bit_count),
        .last  (w_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode r_state only; start and q0 affect the next state alone.
    always_comb begin
        w_next  = r_state;
        m_load  = 1'b0;
        q_load  = 1'b0;
        a_clear = 1'b0;
        a_add   = 1'b0;
        shift   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        w_clr   = 1'b0;
        w_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                m_load  = 1'b1;
                q_load  = 1'b1;
                a_clear = 1'b1;
                w_clr   = 1'b1;
                w_next  = TEST;
            end
            TEST: begin
                busy   = 1'b1;
                w_next = q0 ? ADD : SHIFT;
            end
            ADD: begin
                busy   = 1'b1;
                a_add  = 1'b1;
                w_next = SHIFT;
            end
            SHIFT: begin
                busy  = 1'b1;
                shift = 1'b1;
                // Clearing on the final shift keeps bit_count at 0 through DONE and IDLE.
                if (w_last) begin
                    w_clr  = 1'b1;
                    w_next = DONE;
                end else begin
                    w_inc  = 1'b1;
                    w_next = TEST;
                end
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - scoreboard bench for mult_seq_ctrl
module tb_mult_seq_ctrl;
    import mult_pkg::*;

    localparam int W  = 4;
    localparam int CW = cnt_width(W);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          q0    = 1'b0;
    logic          m_load, q_load, a_clear, a_add, shift, busy, done;
    logic [CW-1:0] bit_count;

    always #5 clock = ~clock;

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .q0        (q0),
        .m_load    (m_load),
        .q_load    (q_load),
        .a_clear   (a_clear),
        .a_add     (a_add),
        .shift     (shift),
        .busy      (busy),
        .done      (done),
        .bit_count (bit_count)
    );

    typedef struct {
        int done_cyc;
        int adds;
        int shifts;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] operand = '0;
    logic [W-1:0] tb_q    = '0;

    int cyc = 0, busyc = 0, adds = 0, shifts = 0, mloads = 0;
    int done_total = 0, gcyc = 0, last_done_t = -100, last_load_t = -100;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor plus a stub Q register that feeds q0 back to the DUT.
    always @(negedge clock) begin
        gcyc++;
        if (reset) begin
            cyc = 0;
        end else begin
            check_eq("add_shift_excl", int'(a_add & shift), 0);
            check_eq("bc_range", int'(int'(bit_count) <= W - 1), 1);
            check_eq("load_group", int'({m_load, q_load, a_clear} inside {3'b000, 3'b111}), 1);
            if (m_load) begin
                cyc         = 1;
                busyc       = int'(busy);
                adds        = 0;
                shifts      = 0;
                mloads      = 1;
                last_load_t = gcyc;
                tb_q        = operand;
                check_eq("bc_in_load", int'(bit_count), 0);
            end else if (cyc > 0) begin
                cyc++;
                busyc  += int'(busy);
                adds   += int'(a_add);
                shifts += int'(shift);
                mloads += int'(m_load);
            end
            if (shift) tb_q = tb_q >> 1;
            if (done) begin
                done_total++;
                last_done_t = gcyc;
                check_eq("bc_in_done", int'(bit_count), 0);
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected_done", 0, 1);
                end else begin
                    e_mon = sb.pop_front();
                    check_eq("done_cycle", cyc, e_mon.done_cyc);
                    check_eq("add_pulses", adds, e_mon.adds);
                    check_eq("shift_pulses", shifts, e_mon.shifts);
                    check_eq("mload_pulses", mloads, 1);
                    check_eq("busy_cycles", busyc, e_mon.done_cyc);
                end
                cyc = 0;
            end
        end
        q0 = tb_q[0];
    end

    function automatic exp_t make_exp(input logic [W-1:0] q);
        exp_t e;
        e.done_cyc = 2 + 2 * W + $countones(q);
        e.adds     = $countones(q);
        e.shifts   = W;
        return e;
    endfunction

    task automatic wait_done(input int tgt, input int budget);
        int n = 0;
        while (done_total < tgt && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        check_eq("done_timeout", int'(done_total >= tgt), 1);
    endtask

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] q, input bit poke);
        int tgt;
        operand = q;
        sb.push_back(make_exp(q));
        tgt = done_total + 1;
        pulse_start();
        if (poke) begin
            repeat (2) @(posedge clock);
            #1 start = 1'b1;
            @(posedge clock); #1 start = 1'b0;
            repeat (3) @(posedge clock);
            #1 start = 1'b1;
            @(posedge clock); #1 start = 1'b0;
        end
        wait_done(tgt, 40);
        @(posedge clock); #1;
        check_eq("idle_busy", int'(busy), 0);
        check_eq("idle_bc", int'(bit_count), 0);
        repeat (3) @(posedge clock);
        #1;
        check_eq("single_done", done_total, tgt);
    endtask

    initial begin
        int   t1, base, tgt;
        // Scenario 1: reset then idle
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_eq("idle_outputs", int'({busy, done, m_load, q_load, a_clear, a_add, shift}), 0);
            check_eq("idle_bitcount", int'(bit_count), 0);
            @(posedge clock); #1;
        end

        // Scenarios 2 and 3
        run_op(4'b1011, 1'b0);
        run_op(4'b0000, 1'b0);
        run_op(4'b1111, 1'b0);

        // Scenario 4: start raised while busy is ignored
        run_op(4'b1011, 1'b1);
        run_op(4'b0000, 1'b1);

        // Scenario 5: start held high, back-to-back with one IDLE cycle
        operand = 4'b0110;
        sb.push_back(make_exp(4'b0110));
        sb.push_back(make_exp(4'b0110));
        tgt = done_total + 2;
        @(posedge clock); #1 start = 1'b1;
        wait_done(done_total + 1, 40);
        t1 = last_done_t;
        wait_done(tgt, 40);
        start = 1'b0;
        check_eq("b2b_gap", last_load_t - t1, 2);
        repeat (4) @(posedge clock);
        #1;
        check_eq("b2b_sb_empty", sb.size(), 0);
        check_eq("b2b_dones", done_total, tgt);

        // Scenario 6: reset during ADD of iteration 2
        operand = 4'b1011;
        sb.push_back(make_exp(4'b1011));
        pulse_start();
        repeat (5) @(posedge clock);
        #1;
        check_eq("in_add_iter2", int'(a_add), 1);
        check_eq("bc_iter2", int'(bit_count), 1);
        reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        check_eq("post_reset_outputs", int'({busy, done, m_load, q_load, a_clear, a_add, shift}), 0);
        check_eq("post_reset_bc", int'(bit_count), 0);
        void'(sb.pop_back());
        base = done_total;
        repeat (15) @(posedge clock);
        #1;
        check_eq("no_done_after_abort", done_total, base);
        run_op(4'b1011, 1'b0);

        check_eq("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
